// File: rtl/mem_trace_pkg.sv
// mem_trace_pkg
//   Shared encodings for the memory-write trace capture unit.
//   - trace_state_e : capture FSM states, also driven onto the state output
//   - MODE_STOP / MODE_WRAP : values of the WRAP_MODE parameter
package mem_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_STOPPED = 2'd2
   } trace_state_e;

   localparam int MODE_STOP = 0;   // stop capturing once the buffer fills
   localparam int MODE_WRAP = 1;   // overwrite the oldest entry when full

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   Storage for captured trace entries: a power-of-two circular buffer with
//   first-word-fall-through head output and optional overwrite-on-full.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   clear        : synchronous flush of pointers and count (dominates push/pop)
//   push, wdata  : append an entry
//   pop          : drop the head entry (caller only pops when count != 0)
//   wrap_en      : when full and not popping, a push replaces the oldest entry
//   head         : current head entry, zero while empty
//   count        : entries held, 0..DEPTH
//   overwrite    : pulses in the cycle a push displaces the oldest entry
module trace_fifo
   import mem_trace_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     wrap_en,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overwrite
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] mem [DEPTH];

   logic full;
   logic do_write;
   logic grow;

   // A push at full is accepted when a pop frees the head in the same cycle,
   // or when wrapping is enabled (the oldest entry is then discarded).
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      do_write  = push && (!full || pop || wrap_en);
      overwrite = push && full && !pop && wrap_en;
      grow      = do_write && !overwrite;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_write) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop || overwrite) begin
            rptr_q <= rptr_q + 1'b1;
         end
         count_q <= count_q + CW'(grow) - CW'(pop);
      end
   end

   // Storage needs no reset: head is masked to zero whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (do_write && !clear) begin
         mem[wptr_q] <= wdata;
      end
   end

   assign head  = (count_q != '0) ? mem[rptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/mem_trace_buffer.sv
// mem_trace_buffer
//   Captures data-memory write events whose address lies in
//   [filter_lo, filter_hi] together with a cycle timestamp, and presents them
//   on a first-word-fall-through readout port.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   arm / disarm          : pulses; arm clears and starts capture, disarm stops
//                           capture keeping contents (disarm wins if both)
//   filter_lo, filter_hi  : inclusive unsigned address window
//   wr_valid/addr/data    : observed memory write
//   rd_ready, rd_valid, rd_addr, rd_data, rd_ts : readout port
//   count, dropped, state : occupancy, saturating lost-event count, FSM state
//
// Readout handshake: rd_valid is high whenever count != 0 and rd_* then show
// the oldest entry; an entry is consumed in any cycle where rd_valid and
// rd_ready are both high, and rd_valid never depends on rd_ready.
module mem_trace_buffer
   import mem_trace_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int TS_WIDTH   = 16,
   parameter int DROP_WIDTH = 8,
   parameter int WRAP_MODE  = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    arm,
   input  logic                    disarm,
   input  logic [ADDR_WIDTH-1:0]   filter_lo,
   input  logic [ADDR_WIDTH-1:0]   filter_hi,
   input  logic                    wr_valid,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    rd_ready,
   output logic                    rd_valid,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic [TS_WIDTH-1:0]     rd_ts,
   output logic [$clog2(DEPTH):0]  count,
   output logic [DROP_WIDTH-1:0]   dropped,
   output logic [1:0]              state
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH + TS_WIDTH;

   trace_state_e          state_q, state_d;
   logic [TS_WIDTH-1:0]   ts_q;
   logic [DROP_WIDTH-1:0] dropped_q;
   logic [EW-1:0]         head;
   logic                  arm_eff, in_range, hit, push, pop, stop_drop, fills, overwrite;

   // Qualification. In the arm cycle both the write and any pop are discarded,
   // since the buffer is being flushed anyway.
   always_comb begin
      arm_eff   = arm && !disarm;
      in_range  = (wr_addr >= filter_lo) && (wr_addr <= filter_hi);
      hit       = wr_valid && in_range && !arm_eff;
      push      = hit && (state_q == ST_CAPTURE);
      stop_drop = hit && (state_q == ST_STOPPED);
      pop       = rd_valid && rd_ready && !arm_eff;
      fills     = push && !pop && (count == CW'(DEPTH - 1)) && (WRAP_MODE == MODE_STOP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arm_eff) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (disarm)     state_d = ST_IDLE;
            else if (arm)   state_d = ST_CAPTURE;
            else if (fills) state_d = ST_STOPPED;
         end
         ST_STOPPED: begin
            if (disarm)   state_d = ST_IDLE;
            else if (arm) state_d = ST_CAPTURE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Timestamp runs in CAPTURE and STOPPED, holds in IDLE, wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q <= '0;
      end else if (arm_eff) begin
         ts_q <= '0;
      end else if (state_q != ST_IDLE) begin
         ts_q <= ts_q + 1'b1;
      end
   end

   // overwrite only fires in CAPTURE and stop_drop only in STOPPED, so at
   // most one increment per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dropped_q <= '0;
      end else if (arm_eff) begin
         dropped_q <= '0;
      end else if ((stop_drop || overwrite) && (dropped_q != '1)) begin
         dropped_q <= dropped_q + 1'b1;
      end
   end

   trace_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (arm_eff),
      .push      (push),
      .pop       (pop),
      .wrap_en   (WRAP_MODE == MODE_WRAP),
      .wdata     ({wr_addr, wr_data, ts_q}),
      .head      (head),
      .count     (count),
      .overwrite (overwrite)
   );

   assign rd_valid = (count != '0);
   assign {rd_addr, rd_data, rd_ts} = head;
   assign dropped  = dropped_q;
   assign state    = state_q;

endmodule

// File: tb/tb_mem_trace_buffer.sv
// Bench for mem_trace_buffer: two instances (stop mode and wrap mode) share
// one stimulus stream; a queue model per instance predicts the readout.
module tb_mem_trace_buffer;

   localparam int EW = 72;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        arm = 1'b0, disarm = 1'b0;
   logic [31:0] filter_lo = 32'h100, filter_hi = 32'h1ff;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_addr = '0, wr_data = '0;
   logic        rd_ready = 1'b0;

   logic        rd_valid0, rd_valid1;
   logic [31:0] rd_addr0, rd_addr1, rd_data0, rd_data1;
   logic [7:0]  rd_ts0, rd_ts1, dropped0, dropped1;
   logic [2:0]  count0, count1;
   logic [1:0]  state0, state1;

   int total = 0;
   int bad   = 0;

   // scoreboard / model state
   logic [EW-1:0] exp0_q[$];
   logic [EW-1:0] exp1_q[$];
   logic [7:0]    m_ts = '0;
   bit            m_on = 0, m_stop0 = 0;
   int            m_drop0 = 0, m_drop1 = 0;
   logic [31:0]   d[6];

   mem_trace_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .TS_WIDTH(8),
                      .DROP_WIDTH(8), .WRAP_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .arm(arm), .disarm(disarm),
      .filter_lo(filter_lo), .filter_hi(filter_hi),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_ready(rd_ready), .rd_valid(rd_valid0), .rd_addr(rd_addr0),
      .rd_data(rd_data0), .rd_ts(rd_ts0), .count(count0),
      .dropped(dropped0), .state(state0));

   mem_trace_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .TS_WIDTH(8),
                      .DROP_WIDTH(8), .WRAP_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .arm(arm), .disarm(disarm),
      .filter_lo(filter_lo), .filter_hi(filter_hi),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_ready(rd_ready), .rd_valid(rd_valid1), .rd_addr(rd_addr1),
      .rd_data(rd_data1), .rd_ts(rd_ts1), .count(count1),
      .dropped(dropped1), .state(state1));

   // clock / reset
   always #5 clk = ~clk;

   task automatic model_reset();
      exp0_q.delete(); exp1_q.delete();
      m_ts = '0; m_on = 0; m_stop0 = 0; m_drop0 = 0; m_drop1 = 0;
   endtask

   // Advance the model with the inputs currently driven, then clock the DUTs.
   task automatic clk_step();
      bit arm_e, hit, pop0, pop1;
      arm_e = arm && !disarm;
      hit   = wr_valid && (wr_addr >= filter_lo) && (wr_addr <= filter_hi);
      pop0  = rd_ready && (exp0_q.size() != 0);
      pop1  = rd_ready && (exp1_q.size() != 0);
      if (arm_e) begin
         exp0_q.delete(); exp1_q.delete();
         m_ts = '0; m_on = 1; m_stop0 = 0; m_drop0 = 0; m_drop1 = 0;
      end else begin
         if (pop0) void'(exp0_q.pop_front());
         if (pop1) void'(exp1_q.pop_front());
         if (hit && m_on && !m_stop0) begin
            exp0_q.push_back({wr_addr, wr_data, m_ts});
            if (exp0_q.size() == 4) m_stop0 = 1;
         end else if (hit && m_on && m_stop0) begin
            if (m_drop0 < 255) m_drop0++;
         end
         if (hit && m_on) begin
            exp1_q.push_back({wr_addr, wr_data, m_ts});
            if (exp1_q.size() > 4) begin
               void'(exp1_q.pop_front());
               if (m_drop1 < 255) m_drop1++;
            end
         end
         if (m_on) m_ts = m_ts + 8'd1;
         if (disarm) begin m_on = 0; m_stop0 = 0; end
      end
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic do_arm(input logic v, input logic [31:0] a);
      arm = 1'b1; wr_valid = v; wr_addr = a; wr_data = $urandom;
      clk_step();
      arm = 1'b0; wr_valid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] dv, input logic rdy);
      wr_valid = 1'b1; wr_addr = a; wr_data = dv; rd_ready = rdy;
      clk_step();
      wr_valid = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic do_idle();
      clk_step();
   endtask

   task automatic test_reset();
      total++;
      if ({state0, count0, rd_valid0, dropped0, rd_addr0, rd_data0, rd_ts0} !== '0) begin
         bad++;
         $display("FAIL reset_state: got st=%0d cnt=%0d v=%0b drop=%0d a=%h d=%h ts=%h want all 0",
                  state0, count0, rd_valid0, dropped0, rd_addr0, rd_data0, rd_ts0);
      end
      do_arm(1'b0, '0);
      for (int i = 0; i < 3; i++) do_write(32'h100 + 32'(i), $urandom, 1'b0);
      total++;
      if (count0 !== 3'd3) begin bad++; $display("FAIL reset_precount: got %0d want 3", count0); end
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      total++;
      if ({state0, count0, rd_valid0, dropped0} !== '0) begin
         bad++;
         $display("FAIL reset_mid: got st=%0d cnt=%0d v=%0b drop=%0d want 0 0 0 0",
                  state0, count0, rd_valid0, dropped0);
      end
      reset = 1'b1;
      do_idle();
   endtask

   task automatic test_filter();
      do_arm(1'b0, '0);                    // ts 0 in the following cycle
      do_idle(); do_idle();
      do_write(32'h104, 32'haaaa_0001, 1'b0);  // ts 2
      do_write(32'h080, 32'haaaa_0002, 1'b0);  // ts 3, filtered
      do_idle();
      do_write(32'h1ff, 32'haaaa_0003, 1'b0);  // ts 5
      total++;
      if (count0 !== 3'd2) begin bad++; $display("FAIL filter_count: got %0d want 2", count0); end
      total++;
      if ({rd_addr0, rd_ts0} !== {32'h104, 8'd2}) begin
         bad++; $display("FAIL filter_head: got %h ts %0d want 104 ts 2", rd_addr0, rd_ts0);
      end
      for (int i = 0; i < 4; i++) begin
         if (exp0_q.size() == 0) break;
         total++;
         if ({rd_valid0, rd_addr0, rd_data0, rd_ts0} !== {1'b1, exp0_q[0]}) begin
            bad++; $display("FAIL filter_read%0d: got %h want %h", i,
                            {rd_valid0, rd_addr0, rd_data0, rd_ts0}, {1'b1, exp0_q[0]});
         end
         rd_ready = 1'b1; clk_step(); rd_ready = 1'b0;
      end
      // inverted window: nothing may qualify
      filter_lo = 32'h200; filter_hi = 32'h100;
      do_write(32'h180, $urandom, 1'b0);
      do_write(32'h200, $urandom, 1'b0);
      total++;
      if (count0 !== 3'(exp0_q.size()) || count0 !== 3'd0) begin
         bad++; $display("FAIL filter_inverted: got %0d want 0", count0);
      end
      filter_lo = 32'h100; filter_hi = 32'h1ff;
   endtask

   task automatic test_stop_wrap();
      for (int i = 0; i < 6; i++) d[i] = $urandom;
      do_arm(1'b1, 32'h110);                   // write in the arm cycle is discarded
      for (int i = 0; i < 6; i++) begin
         do_write(32'h100 + 32'(i * 4), d[i], 1'b0);
         if (i == 3) begin
            total++;
            if ({state0, count0} !== {2'd2, 3'd4}) begin
               bad++; $display("FAIL stop_enter: got st=%0d cnt=%0d want 2 4", state0, count0);
            end
         end
      end
      total++;
      if ({state0, count0, dropped0} !== {2'd2, 3'd4, 8'd2}) begin
         bad++; $display("FAIL stop_final: got st=%0d cnt=%0d drop=%0d want 2 4 2", state0, count0, dropped0);
      end
      total++;
      if ({state1, count1, dropped1} !== {2'd1, 3'd4, 8'd2}) begin
         bad++; $display("FAIL wrap_final: got st=%0d cnt=%0d drop=%0d want 1 4 2", state1, count1, dropped1);
      end
      total++;
      if ({rd_data0, rd_data1} !== {d[0], d[2]}) begin
         bad++; $display("FAIL stopwrap_head: got %h %h want %h %h", rd_data0, rd_data1, d[0], d[2]);
      end
      for (int i = 0; i < 6; i++) begin
         if (exp0_q.size() == 0 && exp1_q.size() == 0) break;
         if (exp0_q.size() != 0) begin
            total++;
            if ({rd_valid0, rd_addr0, rd_data0, rd_ts0} !== {1'b1, exp0_q[0]}) begin
               bad++; $display("FAIL stop_read%0d: got %h want %h", i,
                               {rd_valid0, rd_addr0, rd_data0, rd_ts0}, {1'b1, exp0_q[0]});
            end
         end
         if (exp1_q.size() != 0) begin
            total++;
            if ({rd_valid1, rd_addr1, rd_data1, rd_ts1} !== {1'b1, exp1_q[0]}) begin
               bad++; $display("FAIL wrap_read%0d: got %h want %h", i,
                               {rd_valid1, rd_addr1, rd_data1, rd_ts1}, {1'b1, exp1_q[0]});
            end
         end
         rd_ready = 1'b1; clk_step(); rd_ready = 1'b0;
      end
      total++;
      if ({state0, count0, count1, rd_valid0} !== {2'd2, 3'd0, 3'd0, 1'b0}) begin
         bad++; $display("FAIL stop_drained: got st=%0d c0=%0d c1=%0d v=%0b want 2 0 0 0",
                         state0, count0, count1, rd_valid0);
      end
   endtask

   task automatic test_full_pop();
      logic [31:0] nd;
      do_arm(1'b0, '0);
      for (int i = 0; i < 4; i++) do_write(32'h140 + 32'(i), $urandom, 1'b0);
      nd = $urandom;
      total++;
      if ({rd_addr0, rd_data0, rd_ts0, rd_addr1, rd_data1, rd_ts1} !== {exp0_q[0], exp1_q[0]}) begin
         bad++; $display("FAIL fullpop_head: got %h %h want %h %h",
                         {rd_addr0, rd_data0, rd_ts0}, {rd_addr1, rd_data1, rd_ts1}, exp0_q[0], exp1_q[0]);
      end
      do_write(32'h150, nd, 1'b1);
      total++;
      if ({state1, count1, dropped1} !== {2'd1, 3'd4, 8'(m_drop1)} || m_drop1 != 0) begin
         bad++; $display("FAIL fullpop_wrap: got st=%0d cnt=%0d drop=%0d want 1 4 0", state1, count1, dropped1);
      end
      total++;
      if ({state0, count0, dropped0} !== {2'd2, 3'd3, 8'd1}) begin
         bad++; $display("FAIL fullpop_stop: got st=%0d cnt=%0d drop=%0d want 2 3 1", state0, count0, dropped0);
      end
      for (int i = 0; i < 6; i++) begin
         if (exp1_q.size() == 0) break;
         total++;
         if ({rd_valid1, rd_addr1, rd_data1, rd_ts1} !== {1'b1, exp1_q[0]}) begin
            bad++; $display("FAIL fullpop_read%0d: got %h want %h", i,
                            {rd_valid1, rd_addr1, rd_data1, rd_ts1}, {1'b1, exp1_q[0]});
         end
         if (exp1_q.size() == 1) begin
            total++;
            if ({rd_addr1, rd_data1} !== {32'h150, nd}) begin
               bad++; $display("FAIL fullpop_tail: got %h %h want 150 %h", rd_addr1, rd_data1, nd);
            end
         end
         rd_ready = 1'b1; clk_step(); rd_ready = 1'b0;
      end
   endtask

   task automatic test_saturate();
      do_arm(1'b0, '0);
      for (int i = 0; i < 304; i++) do_write(32'h1f0, 32'(i), 1'b0);
      total++;
      if ({dropped0, dropped1} !== {8'hff, 8'hff}) begin
         bad++; $display("FAIL saturate: got %0d %0d want 255 255", dropped0, dropped1);
      end
      for (int i = 0; i < 5; i++) begin
         if (exp1_q.size() == 0) break;
         total++;
         if ({rd_valid1, rd_addr1, rd_data1, rd_ts1} !== {1'b1, exp1_q[0]}) begin
            bad++; $display("FAIL saturate_read%0d: got %h want %h", i,
                            {rd_valid1, rd_addr1, rd_data1, rd_ts1}, {1'b1, exp1_q[0]});
         end
         rd_ready = 1'b1; clk_step(); rd_ready = 1'b0;
      end
   endtask

   task automatic test_arm_disarm();
      do_arm(1'b0, '0);
      do_write(32'h1a0, $urandom, 1'b0);
      do_write(32'h1a4, $urandom, 1'b0);
      arm = 1'b1; disarm = 1'b1;
      clk_step();
      arm = 1'b0; disarm = 1'b0;
      total++;
      if ({state0, state1, count0, count1} !== {2'd0, 2'd0, 3'd2, 3'd2}) begin
         bad++; $display("FAIL armdisarm: got st=%0d/%0d cnt=%0d/%0d want 0/0 2/2",
                         state0, state1, count0, count1);
      end
      // pops remain legal in IDLE
      for (int i = 0; i < 4; i++) begin
         if (exp0_q.size() == 0) break;
         total++;
         if ({rd_valid0, rd_addr0, rd_data0, rd_ts0} !== {1'b1, exp0_q[0]}) begin
            bad++; $display("FAIL armdisarm_read%0d: got %h want %h", i,
                            {rd_valid0, rd_addr0, rd_data0, rd_ts0}, {1'b1, exp0_q[0]});
         end
         rd_ready = 1'b1; clk_step(); rd_ready = 1'b0;
      end
      total++;
      if ({state0, count0, rd_valid0} !== {2'd0, 3'd0, 1'b0}) begin
         bad++; $display("FAIL armdisarm_drained: got st=%0d cnt=%0d v=%0b want 0 0 0", state0, count0, rd_valid0);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      do_idle();
      test_reset();
      test_filter();
      test_stop_wrap();
      test_full_pop();
      test_saturate();
      test_arm_disarm();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
